// File: rtl/scl_staller_multi.sv
// rtl/scl_staller_multi.sv - programmable SCL stall generator with prescale, abort and four-phase handshake
module scl_staller_multi #(
    parameter int   CNT_W    = 8,
    parameter int   PRE_W    = 4,
    parameter logic SCL_IDLE = 1'b1
) (
    input  logic             i_stall_clk,
    input  logic             i_stall_rst,
    input  logic             i_stall_flag,
    input  logic [CNT_W-1:0] i_stall_cycles,
    input  logic [PRE_W-1:0] i_stall_prescale,
    input  logic [1:0]       i_stall_mode,
    input  logic             i_stall_abort,
    output logic             o_stall_done,
    output logic             o_scl_stall,
    output logic             o_stall_active,
    output logic [CNT_W-1:0] o_stall_remaining,
    output logic             o_stall_err
);

    typedef enum logic [1:0] {S_IDLE, S_STALL, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [PRE_W-1:0] r_prescale;
    logic [1:0]       r_mode;
    logic             r_done;
    logic             r_scl;
    logic             r_active;
    logic [CNT_W-1:0] r_remaining;
    logic             r_err;
    logic             w_finish;

    // Last clock of the last unit, or abort; both land in the same DONE state.
    assign w_finish = i_stall_abort || (r_pre_cnt == '0 && r_remaining <= CNT_ONE);

    always_ff @(posedge i_stall_clk) begin
        if (i_stall_rst) begin
            r_state     <= S_IDLE;
            r_pre_cnt   <= '0;
            r_prescale  <= '0;
            r_mode      <= 2'b00;
            r_done      <= 1'b0;
            r_scl       <= SCL_IDLE;
            r_active    <= 1'b0;
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_stall_flag) begin
                        r_prescale <= i_stall_prescale;
                        r_mode     <= i_stall_mode;
                        if (i_stall_cycles == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= S_STALL;
                            r_active    <= 1'b1;
                            r_remaining <= i_stall_cycles;
                            r_pre_cnt   <= i_stall_prescale;
                            r_scl       <= (i_stall_mode == 2'b01);
                            r_err       <= (i_stall_mode == 2'b11);
                        end
                    end
                end
                S_STALL: begin
                    if (w_finish) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_active    <= 1'b0;
                        r_scl       <= SCL_IDLE;
                        r_remaining <= '0;
                        r_pre_cnt   <= '0;
                    end else if (r_pre_cnt != '0) begin
                        r_pre_cnt <= r_pre_cnt - PRE_ONE;
                    end else begin
                        r_pre_cnt   <= r_prescale;
                        r_remaining <= r_remaining - CNT_ONE;
                        if (r_mode == 2'b10) begin
                            r_scl <= ~r_scl;
                        end
                    end
                end
                S_DONE: begin
                    // Leaving only on a low flag keeps a held request from retriggering.
                    if (!i_stall_flag) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_stall_done      = r_done;
    assign o_scl_stall       = r_scl;
    assign o_stall_active    = r_active;
    assign o_stall_remaining = r_remaining;
    assign o_stall_err       = r_err;

endmodule

// File: tb/tb_scl_staller_multi.sv
// tb/tb_scl_staller_multi.sv - directed scoreboard bench for scl_staller_multi
module tb_scl_staller_multi;

    localparam int CNT_W = 8;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flag;
    logic [CNT_W-1:0] cycles;
    logic [PRE_W-1:0] prescale;
    logic [1:0]       mode;
    logic             abort;
    logic             done;
    logic             scl;
    logic             active;
    logic [CNT_W-1:0] remaining;
    logic             err;

    int checks = 0;
    int errors = 0;
    logic [CNT_W:0] sb[$];

    scl_staller_multi #(.CNT_W(CNT_W), .PRE_W(PRE_W), .SCL_IDLE(1'b1)) dut (
        .i_stall_clk      (clk),
        .i_stall_rst      (rst),
        .i_stall_flag     (flag),
        .i_stall_cycles   (cycles),
        .i_stall_prescale (prescale),
        .i_stall_mode     (mode),
        .i_stall_abort    (abort),
        .o_stall_done     (done),
        .o_scl_stall      (scl),
        .o_stall_active   (active),
        .o_stall_remaining(remaining),
        .o_stall_err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input logic exp_done);
        chk({tag, "_active"}, {31'd0, active}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, "_scl"}, {31'd0, scl}, 32'd1);
        chk({tag, "_remaining"}, {24'd0, remaining}, 32'd0);
    endtask

    // Model: one scoreboard entry {scl, remaining} per expected active clock.
    task automatic run_stall(input string tag, input int c, input int p, input logic [1:0] m,
                             input int abort_at, input int drop_at);
        int total;
        int n;
        logic [CNT_W:0] e;
        total = (abort_at != 0) ? abort_at : c * (p + 1);
        for (int u = 0; u < c; u++) begin
            for (int k = 0; k <= p; k++) begin
                if (sb.size() < total) begin
                    e[CNT_W]     = (m == 2'b01) ? 1'b1 : ((m == 2'b10) ? u[0] : 1'b0);
                    e[CNT_W-1:0] = CNT_W'(c - u);
                    sb.push_back(e);
                end
            end
        end
        flag = 1'b1; cycles = CNT_W'(c); prescale = PRE_W'(p); mode = m;
        tick();
        cycles = '0; prescale = '0; mode = 2'b00;
        n = 0;
        while (active === 1'b1 && n < 5000) begin
            if (n == 0) chk({tag, "_err_first"}, {31'd0, err}, {31'd0, (m == 2'b11)});
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (scl !== e[CNT_W] || remaining !== e[CNT_W-1:0])
                    chk({tag, "_cycle"}, {23'd0, scl, remaining}, {23'd0, e});
            end
            if (abort_at != 0 && n + 1 == abort_at) abort = 1'b1;
            if (drop_at != 0 && n + 1 == drop_at) flag = 1'b0;
            tick();
            abort = 1'b0;
            n++;
        end
        chk({tag, "_active_len"}, n, total);
        chk({tag, "_sb_left"}, sb.size(), 0);
        sb.delete();
        chk_idle_outputs({tag, "_end"}, 1'b1);
    endtask

    task automatic release_flag(input string tag);
        flag = 1'b0;
        tick();
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flag = 1'b0; cycles = '0; prescale = '0; mode = 2'b00; abort = 1'b0;
        repeat (3) tick();
        chk_idle_outputs("reset", 1'b0);
        chk("reset_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick();

        run_stall("basic", 5, 0, 2'b00, 0, 0);
        release_flag("basic");

        run_stall("toggle", 3, 2, 2'b10, 0, 0);
        release_flag("toggle");

        run_stall("high", 3, 2, 2'b01, 0, 0);
        release_flag("high");

        run_stall("abort", 200, 0, 2'b00, 10, 0);
        release_flag("abort");

        flag = 1'b1; cycles = '0;
        tick();
        chk_idle_outputs("zero", 1'b1);
        chk("zero_err", {31'd0, err}, 32'd1);
        tick();
        chk("zero_err_pulse", {31'd0, err}, 32'd0);
        chk("zero_hold_done", {31'd0, done}, 32'd1);
        release_flag("zero");

        run_stall("reserved", 2, 0, 2'b11, 0, 0);
        chk("reserved_err_clear", {31'd0, err}, 32'd0);
        repeat (20) begin
            tick();
            if (active !== 1'b0 || done !== 1'b1)
                chk("held_no_retrigger", {30'd0, active, done}, 32'd1);
        end
        chk("held_state", {30'd0, active, done}, 32'd1);
        release_flag("held");

        run_stall("retrigger", 4, 1, 2'b10, 0, 0);
        release_flag("retrigger");

        run_stall("flag_drop", 6, 1, 2'b00, 0, 3);
        tick();
        chk("flag_drop_done", {31'd0, done}, 32'd0);

        flag = 1'b1; cycles = 8'd8; prescale = '0; mode = 2'b10;
        tick();
        for (int i = 0; i < 20 && remaining !== 8'd4; i++) tick();
        chk("rst_mid_remaining", {24'd0, remaining}, 32'd4);
        rst = 1'b1; flag = 1'b0;
        tick();
        chk_idle_outputs("rst_mid", 1'b0);
        chk("rst_mid_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick();

        run_stall("max", 255, 15, 2'b00, 0, 0);
        release_flag("max");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scl_staller_multi.md
Name: scl_staller_multi

Overview:
Parametrised successor to the fixed 6-bit SCL staller in the I3C controller TX path. It holds SCL low or high, or toggles it, for a programmable number of stall units. Each unit is stretched by a programmable prescaler. It adds abort, progress visibility, error flagging and a four-phase request/done handshake. It sits between the TX frame FSM, which requests stalls, and the SCL output mux, which selects o_scl_stall while o_stall_active=1.

Parameters:
CNT_W, 8, width of stall-unit count and remaining-count output
PRE_W, 4, width of prescaler value; one unit = prescale+1 clocks
SCL_IDLE, 1'b1, value driven on o_scl_stall whenever not stalling

Ports:
i_stall_clk  in  1  system clock, all logic on rising edge
i_stall_rst  in  1  synchronous reset, active-high
i_stall_flag  in  1  stall request, level; held high until o_stall_done seen
i_stall_cycles  in  CNT_W  number of stall units, sampled at acceptance
i_stall_prescale  in  PRE_W  clocks-per-unit minus 1, sampled at acceptance
i_stall_mode  in  2  00 hold low, 01 hold high, 10 toggle, 11 reserved
i_stall_abort  in  1  terminate active stall
o_stall_done  out  1  completion, level, four-phase with i_stall_flag
o_scl_stall  out  1  SCL value during stall
o_stall_active  out  1  high while in STALL
o_stall_remaining  out  CNT_W  units still to run (including current)
o_stall_err  out  1  one-cycle pulse on illegal request

Behaviour:
- Clock and reset: one clock. Synchronous active-high reset.
- Reset values: state IDLE, o_scl_stall=SCL_IDLE, o_stall_done=0, o_stall_active=0, o_stall_remaining=0, o_stall_err=0, internal counters 0.
- Reset mid-operation: all reset values take effect at the next edge regardless of state.
- States: IDLE, STALL, DONE.
- IDLE:
  - If i_stall_flag=1 at an edge, latch cycles, prescale and mode.
  - cycles!=0: next state STALL.
  - cycles==0: next state DONE, o_stall_err=1 for that first cycle.
  - mode=11: run as hold-low and pulse o_stall_err=1 in the first STALL cycle.
  - i_stall_abort is ignored in IDLE.
- STALL entry (first cycle after acceptance):
  - o_stall_active=1, o_stall_remaining=cycles, prescale counter=prescale.
  - o_scl_stall = 0 for modes 00/10/11, 1 for mode 01.
- STALL, each edge:
  - Prescale counter !=0: decrement it.
  - Prescale counter ==0: reload prescale and decrement remaining.
  - Mode 10 only: o_scl_stall inverts at every unit boundary.
  - Remaining 1 with counter 0: go to DONE.
  - Total o_stall_active high time is exactly cycles*(prescale+1) clocks.
- Abort: i_stall_abort=1 in STALL sends the next state to DONE and clears remaining to 0. Abort in the same cycle as natural completion gives the identical result.
- Flag drop mid-stall: deassertion of i_stall_flag during STALL is ignored; the stall runs to completion or abort.
- DONE:
  - o_stall_done=1, o_stall_active=0, o_scl_stall=SCL_IDLE, remaining=0.
  - Stays in DONE while i_stall_flag=1.
  - First edge with i_stall_flag=0: go to IDLE, o_stall_done=0.
  - No new request is accepted until the flag has been seen low, so a held flag never retriggers.
- Width rules: cycles up to 2^CNT_W-1 and prescale up to 2^PRE_W-1. Counters never wrap; remaining saturates at 0.
- Stable inputs: inputs other than flag and abort are don't-care outside the acceptance cycle.

Test Plan:
- Basic hold-low: reset 3 cycles, flag=1, cycles=5, prescale=0, mode=00 -> active high exactly 5 clocks with o_scl_stall=0, remaining 5,4,3,2,1. Then done=1 and scl=1. Drop flag -> done=0 one clock later.
- Prescale plus toggle: cycles=3, prescale=2, mode=10 -> active 9 clocks, scl pattern 000111000, done after. Mode 01 with the same counts -> scl=1 for 9 clocks.
- Abort: cycles=200, prescale=0, assert abort on the 10th active clock -> active falls next clock, remaining=0, done=1, scl=SCL_IDLE.
- Illegal requests: cycles=0 -> no active cycle, done next clock, err pulse 1 clock. Mode=11 with cycles=2 -> 2 hold-low clocks, err pulse on the first.
- Handshake and retrigger: keep flag high 20 clocks after done -> no second stall. Drop flag then raise it again -> new stall starts. Drop flag mid-stall -> stall still completes full length.
- Reset mid-stall: assert i_stall_rst during STALL with remaining=4 -> all outputs at reset values next edge. Max cycles=255, prescale=15 -> 4080 active clocks, with no wrap.
